fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_unit_next_pc_logic.sv | 38 +++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetch_state_t;

    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_J     = 6'h02;
    localparam logic [5:0]  OP_BEQ   = 6'h04;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// Combinational next-PC selection: sequential, branch-relative or jump-absolute.
module next_pc_logic #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] pc,
    input  logic [31:0]  instr,
    input  logic         pcsrc,
    input  logic         jump,
    output logic [N-1:0] pcplus4,
    output logic [N-1:0] next_pc
);

    logic [N-1:0] w_br_offset;
    logic [N-1:0] w_jump_target;
    logic         w_unused_opfield;

    assign pcplus4     = pc + N'(4);
    assign w_br_offset = {{(N-18){instr[15]}}, instr[15:0], 2'b00};

    // Jump keeps the upper region bits of pc+4; a 28-bit PC has no region bits.
    if (N > 28) begin : g_region
        assign w_jump_target = {pcplus4[N-1:28], instr[25:0], 2'b00};
    end else begin : g_noregion
        assign w_jump_target = {instr[25:0], 2'b00};
    end

    assign w_unused_opfield = ^instr[31:26];

    always_comb begin
        next_pc = pcplus4;
        if (jump) begin
            next_pc = w_jump_target;
        end else if (pcsrc) begin
            next_pc = pcplus4 + w_br_offset;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, wait-state memory handshake, instruction latch.
// Optional FETCH_PERF_EN adds retired_count / wait_count performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned    N        = 32,
    parameter logic [N-1:0]   RESET_PC = N'(FETCH_RESET_PC)
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic [31:0]  imem_rdata,
    input  logic         imem_ready,
    input  logic         stall,
    input  logic         pcsrc,
    input  logic         jump,
    output logic [31:0]  instr,
    output logic [5:0]   op,
    output logic [5:0]   funct,
    output logic         instr_valid,
    output logic [N-1:0] pc,
    output logic [N-1:0] pcplus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  retired_count,
    output logic [31:0]  wait_count
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [N-1:0] r_pc;
    logic [31:0]  r_instr;
    logic [N-1:0] w_next_pc;
    logic [N-1:0] w_pcplus4;
    logic         w_latch;
    logic         w_retire;

    next_pc_logic #(
        .N(N)
    ) u_next_pc (
        .pc      (r_pc),
        .instr   (r_instr),
        .pcsrc   (pcsrc),
        .jump    (jump),
        .pcplus4 (w_pcplus4),
        .next_pc (w_next_pc)
    );

    // imem_req and instr_valid decode straight from state so reset drops them at once.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_retire    = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_latch     = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    w_retire    = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_instr <= imem_rdata;
            end
            if (w_retire) begin
                r_pc <= w_next_pc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_retired_count;
    logic [31:0] r_wait_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired_count <= '0;
            r_wait_count    <= '0;
        end else begin
            if (w_retire) begin
                r_retired_count <= r_retired_count + 32'd1;
            end
            if (imem_req && !imem_ready) begin
                r_wait_count <= r_wait_count + 32'd1;
            end
        end
    end

    assign retired_count = r_retired_count;
    assign wait_count    = r_wait_count;
`endif

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pcplus4   = w_pcplus4;
    assign instr     = r_instr;
    assign op        = r_instr[31:26];
    assign funct     = r_instr[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; perf counters checked when FETCH_PERF_EN is defined.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        pcsrc;
    logic        jump;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
`ifdef FETCH_PERF_EN
    logic [31:0] retired_count;
    logic [31:0] wait_count;
    logic [31:0] ret0;
    logic [31:0] wait0;
`endif

    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(
        .N        (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pcplus4     (pcplus4)
`ifdef FETCH_PERF_EN
        ,
        .retired_count (retired_count),
        .wait_count    (wait_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one full cycle: crosses exactly one rising edge, lands on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    // Stimulus only: from a FETCH cycle, deliver a zero-wait word and retire it.
    task automatic run_instr(input logic [31:0] d, input logic p, input logic j);
        imem_rdata = d;
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        pcsrc      = p;
        jump       = j;
        stall      = 1'b0;
        cyc();
        pcsrc      = 1'b0;
        jump       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_rdata = '0; imem_ready = 1'b0; stall = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        cyc(); cyc();
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 00000000", pc); end
        n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 00000000", instr); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        n_vec++; if ({op, funct} !== 12'h0) begin n_err++; $display("FAIL rst_opfunct: got %h/%h want 00/00", op, funct); end
        reset = 1'b0;
        #1;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", imem_req); end
        cyc();
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL c2_req: got %b want 1", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL c2_addr: got %h want 00000000", imem_addr); end
    endtask

    task automatic test_basic_fetch();
        imem_rdata = 32'h012A_4020; imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", instr_valid); end
        n_vec++; if (instr !== 32'h012A_4020) begin n_err++; $display("FAIL basic_instr: got %h want 012a4020", instr); end
        n_vec++; if (op !== OP_RTYPE) begin n_err++; $display("FAIL basic_op: got %h want 00", op); end
        n_vec++; if (funct !== 6'h20) begin n_err++; $display("FAIL basic_funct: got %h want 20", funct); end
        n_vec++; if (pcplus4 !== 32'h4) begin n_err++; $display("FAIL basic_pc4: got %h want 00000004", pcplus4); end
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL basic_noreq: got %b want 0", imem_req); end
        cyc();
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req2: got %b want 1", imem_req); end
        n_vec++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL basic_addr2: got %h want 00000004", imem_addr); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid2: got %b want 0", instr_valid); end
    endtask

    task automatic test_branch();
        run_instr(32'h0, 1'b0, 1'b0);
        run_instr(32'h0, 1'b0, 1'b0);
        run_instr(32'h0, 1'b0, 1'b0);
        n_vec++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL br_start: got %h want 00000010", imem_addr); end
        imem_rdata = 32'h1109_0003; imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        n_vec++; if (op !== OP_BEQ) begin n_err++; $display("FAIL br_op: got %h want 04", op); end
        pcsrc = 1'b1;
        cyc();
        pcsrc = 1'b0;
        n_vec++; if (imem_addr !== 32'h20) begin n_err++; $display("FAIL br_fwd: got %h want 00000020", imem_addr); end
        run_instr(32'h1109_FFFF, 1'b1, 1'b0);
        n_vec++; if (imem_addr !== 32'h20) begin n_err++; $display("FAIL br_neg: got %h want 00000020", imem_addr); end
    endtask

    task automatic test_jump();
        imem_rdata = 32'h0800_0040; imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        n_vec++; if (op !== OP_J) begin n_err++; $display("FAIL j_op: got %h want 02", op); end
        jump = 1'b1; pcsrc = 1'b1;
        cyc();
        jump = 1'b0; pcsrc = 1'b0;
        n_vec++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL j_target: got %h want 00000100", imem_addr); end
    endtask

    task automatic test_wait_stall();
`ifdef FETCH_PERF_EN
        ret0  = retired_count;
        wait0 = wait_count;
`endif
        imem_rdata = 32'hDEAD_BEEF;
        for (int unsigned i = 0; i < 3; i++) begin
            cyc();
            n_vec++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL ws_addr%0d: got %h want 00000100", i, imem_addr); end
            n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL ws_req%0d: got %b want 1", i, imem_req); end
            n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL ws_valid%0d: got %b want 0", i, instr_valid); end
        end
        imem_rdata = 32'h1109_0005; imem_ready = 1'b1; stall = 1'b1;
        cyc();
        imem_ready = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            pcsrc = (i == 0);
            imem_rdata = 32'hFFFF_FFFF;
            cyc();
            n_vec++; if (instr !== 32'h1109_0005) begin n_err++; $display("FAIL st_instr%0d: got %h want 11090005", i, instr); end
            n_vec++; if (pc !== 32'h100) begin n_err++; $display("FAIL st_pc%0d: got %h want 00000100", i, pc); end
            n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL st_valid%0d: got %b want 1", i, instr_valid); end
            n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL st_req%0d: got %b want 0", i, imem_req); end
        end
        stall = 1'b0; pcsrc = 1'b0;
        cyc();
        n_vec++; if (imem_addr !== 32'h104) begin n_err++; $display("FAIL st_next: got %h want 00000104", imem_addr); end
`ifdef FETCH_PERF_EN
        n_vec++; if (wait_count - wait0 !== 32'd3) begin n_err++; $display("FAIL perf_wait: got %0d want 3", wait_count - wait0); end
        n_vec++; if (retired_count - ret0 !== 32'd1) begin n_err++; $display("FAIL perf_ret: got %0d want 1", retired_count - ret0); end
`endif
    endtask

    task automatic test_wrap();
        run_instr(32'h1109_FFBD, 1'b1, 1'b0);
        n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pre: got %h want fffffffc", imem_addr); end
        imem_rdata = 32'h0; imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        n_vec++; if (pcplus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got %h want 00000000", pcplus4); end
        cyc();
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 00000000", imem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        run_instr(32'h0800_0010, 1'b0, 1'b1);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL mr_pre: got req=%b addr=%h want req=1 addr=00000040", imem_req, imem_addr); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mr_req: got %b want 0", imem_req); end
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL mr_pc: got %h want 00000000", pc); end
        cyc();
        reset = 1'b0;
        #1;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mr_idle: got %b want 0", imem_req); end
        cyc();
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL mr_refetch: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_branch();
        test_jump();
        test_wait_stall();
        test_wrap();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
